sprite_fetch: RTL and testbench

SPRITE_FETCH -- requirements
Module: sprite_fetch

---
 rtl/sprite_pkg.sv | 31 +++
 rtl/sprite_fetch_if.sv | 41 ++++
 rtl/sprite_fetch_anim_counter.sv | 50 +++++
 rtl/sprite_fetch.sv | 110 +++++++++++
 tb/tb_sprite_fetch.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module : sprite_pkg
// Brief  : Shared defaults and sizing helpers for the sprite fetch block.
//          SPRITE_W/H_DEFAULT : sprite dimensions in pixels
//          FRAMES_DEFAULT     : animation frames stored back-to-back in ROM
//          FRAME_DIV_DEFAULT  : video frames per animation step
//          TRANSPARENT_IDX    : palette index treated as "no pixel"
// Rev    : 1.0  initial release
// ============================================================================
package sprite_pkg;

  localparam int SPRITE_W_DEFAULT  = 64;
  localparam int SPRITE_H_DEFAULT  = 96;
  localparam int FRAMES_DEFAULT    = 4;
  localparam int FRAME_DIV_DEFAULT = 8;

  localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

  // Width of the sprite ROM address for a given frame count and sprite size.
  function automatic int addr_w(input int frames, input int w, input int h);
    return $clog2(frames * w * h);
  endfunction

  // Counter width for a modulo-n counter; never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_fetch_if.sv
`default_nettype none
// ============================================================================
// Module : sprite_fetch_if
// Brief  : Raster, sprite-position and ROM signals of the sprite fetch block.
//          master : raster/position source plus the external sprite ROM
//                   (drives coordinates and rom_data, observes outputs)
//          slave  : sprite_fetch itself
// Rev    : 1.0  initial release
// ============================================================================
interface sprite_fetch_if
  import sprite_pkg::*;
#(
  parameter int ADDR_W = addr_w(FRAMES_DEFAULT, SPRITE_W_DEFAULT, SPRITE_H_DEFAULT)
) ();

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              frame_start;
  logic [9:0]        SpriteX;
  logic [9:0]        SpriteY;
  logic              facing_left;
  logic              anim_enable;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [3:0]        pal_index;
  logic              pixel_valid;

  modport master (
    output DrawX, DrawY, frame_start, SpriteX, SpriteY, facing_left,
           anim_enable, rom_data,
    input  rom_addr, pal_index, pixel_valid
  );

  modport slave (
    input  DrawX, DrawY, frame_start, SpriteX, SpriteY, facing_left,
           anim_enable, rom_data,
    output rom_addr, pal_index, pixel_valid
  );

endinterface
`default_nettype wire

// File: rtl/sprite_fetch_anim_counter.sv
`default_nettype none
// ============================================================================
// Module : anim_counter
// Brief  : Animation step divider and frame counter. Advances only on
//          frame_start, so the frame index is stable across a video frame.
//          clk, rst      : clock, synchronous active-high reset
//          frame_start   : one-cycle pulse per video frame
//          anim_enable   : 1 = count, 0 = hold divider and frame
//          anim_frame    : current animation frame, 0..FRAMES-1
// Rev    : 1.0  initial release
// ============================================================================
module anim_counter
  import sprite_pkg::*;
#(
  parameter int FRAMES    = FRAMES_DEFAULT,
  parameter int FRAME_DIV = FRAME_DIV_DEFAULT,
  parameter int FRAME_W   = cnt_w(FRAMES)
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               frame_start,
  input  wire logic               anim_enable,
  output logic      [FRAME_W-1:0] anim_frame
);

  localparam int DIV_W = cnt_w(FRAME_DIV);
  localparam logic [DIV_W-1:0]   c_div_last   = DIV_W'(FRAME_DIV - 1);
  localparam logic [FRAME_W-1:0] c_frame_last = FRAME_W'(FRAMES - 1);

  logic [DIV_W-1:0]   r_div_cnt;
  logic [FRAME_W-1:0] r_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_frame   <= '0;
    end else if (frame_start && anim_enable) begin
      if (r_div_cnt == c_div_last) begin
        r_div_cnt <= '0;
        r_frame   <= (r_frame == c_frame_last) ? '0 : r_frame + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  assign anim_frame = r_frame;

endmodule
`default_nettype wire

// File: rtl/sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module : sprite_fetch
// Brief  : Maps raster coordinates onto an external sprite ROM and returns a
//          palette index with an opacity flag, 3 cycles after the coordinates.
//          Clk, Reset : clock, synchronous active-high reset
//          bus.DrawX/DrawY      : raster coordinates (in)
//          bus.frame_start      : per-frame pulse, latches position/facing (in)
//          bus.SpriteX/SpriteY  : sprite top-left position (in)
//          bus.facing_left      : horizontal mirror (in)
//          bus.anim_enable      : animation advance enable (in)
//          bus.rom_addr         : registered ROM address (out)
//          bus.rom_data         : ROM palette index, one cycle after addr (in)
//          bus.pal_index        : palette index, 0 when not valid (out)
//          bus.pixel_valid      : opaque sprite pixel present (out)
// Rev    : 1.0  initial release
// ============================================================================
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int SPRITE_W  = SPRITE_W_DEFAULT,
  parameter int SPRITE_H  = SPRITE_H_DEFAULT,
  parameter int FRAMES    = FRAMES_DEFAULT,
  parameter int FRAME_DIV = FRAME_DIV_DEFAULT
) (
  input wire logic Clk,
  input wire logic Reset,
  sprite_fetch_if.slave bus
);

  localparam int ADDR_W  = addr_w(FRAMES, SPRITE_W, SPRITE_H);
  localparam int FRAME_W = cnt_w(FRAMES);

  localparam logic [10:0] c_w      = 11'(SPRITE_W);
  localparam logic [10:0] c_h      = 11'(SPRITE_H);
  localparam logic [10:0] c_w_last = 11'(SPRITE_W - 1);

  // Per-frame shadow copies: mid-frame changes on the bus are ignored.
  logic [9:0]        r_sx;
  logic [9:0]        r_sy;
  logic              r_face;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_inb;    // in-bounds flag, one stage per pipeline cycle
  logic [3:0]        r_data;   // ROM data captured alongside r_inb[2]

  logic [FRAME_W-1:0] w_anim_frame;
  logic [10:0]        w_dx, w_dy, w_sx, w_sy;
  logic [10:0]        w_off_x, w_col, w_row;
  logic               w_in;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_valid;

  anim_counter #(
    .FRAMES    (FRAMES),
    .FRAME_DIV (FRAME_DIV),
    .FRAME_W   (FRAME_W)
  ) u_anim (
    .clk         (Clk),
    .rst         (Reset),
    .frame_start (bus.frame_start),
    .anim_enable (bus.anim_enable),
    .anim_frame  (w_anim_frame)
  );

  // 11-bit compares so SpriteX+SPRITE_W past 1023 does not wrap to the left.
  always_comb begin
    w_dx    = {1'b0, bus.DrawX};
    w_dy    = {1'b0, bus.DrawY};
    w_sx    = {1'b0, r_sx};
    w_sy    = {1'b0, r_sy};
    w_in    = (w_dx >= w_sx) && (w_dx < w_sx + c_w) &&
              (w_dy >= w_sy) && (w_dy < w_sy + c_h);
    w_off_x = w_dx - w_sx;
    w_col   = r_face ? (c_w_last - w_off_x) : w_off_x;
    w_row   = w_dy - w_sy;
    w_addr  = ADDR_W'(w_anim_frame) * ADDR_W'(SPRITE_W * SPRITE_H)
            + ADDR_W'(w_row) * ADDR_W'(SPRITE_W)
            + ADDR_W'(w_col);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_face <= 1'b0;
      r_addr <= '0;
      r_inb  <= '0;
      r_data <= '0;
    end else begin
      if (bus.frame_start) begin
        r_sx   <= bus.SpriteX;
        r_sy   <= bus.SpriteY;
        r_face <= bus.facing_left;
      end
      // Out-of-bounds pixels leave the ROM address parked.
      if (w_in) begin
        r_addr <= w_addr;
      end
      r_inb  <= {r_inb[1:0], w_in};
      r_data <= bus.rom_data;
    end
  end

  assign w_valid         = r_inb[2] && (r_data != TRANSPARENT_IDX);
  assign bus.rom_addr    = r_addr;
  assign bus.pixel_valid = w_valid;
  assign bus.pal_index   = w_valid ? r_data : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_sprite_fetch
// Brief  : Self-checking bench for sprite_fetch with a behavioural sprite ROM
//          and a reference model feeding expected-result queues.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sprite_fetch;

  typedef struct {
    logic r; int x; int y; logic fs; int sx; int sy; logic face; logic en;
  } stim_t;
  typedef struct { int due; logic [14:0] addr; } a_item_t;
  typedef struct { int due; logic v; logic [3:0] pal; } p_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  a_item_t qa[$];
  p_item_t qp[$];

  // Reference model state
  int          m_sx, m_sy, m_frame, m_div;
  logic        m_face;
  logic [14:0] m_addr;

  sprite_fetch_if bus ();

  sprite_fetch dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] rom_val(input logic [14:0] a);
    logic [14:0] t;
    t = a + 15'd5;
    return t[3:0];
  endfunction

  // Synchronous sprite ROM: data one cycle after the address.
  always @(posedge clk) bus.rom_data <= rom_val(bus.rom_addr);

  task automatic step(input stim_t s);
    a_item_t ai;
    p_item_t pi;
    bit inb;
    int col, row;
    logic [3:0] d;
    @(posedge clk);
    #1;
    rst             = s.r;
    bus.DrawX       = 10'(s.x);
    bus.DrawY       = 10'(s.y);
    bus.frame_start = s.fs;
    bus.SpriteX     = 10'(s.sx);
    bus.SpriteY     = 10'(s.sy);
    bus.facing_left = s.face;
    bus.anim_enable = s.en;
    if (s.r) begin
      m_sx = 0; m_sy = 0; m_face = 1'b0; m_frame = 0; m_div = 0; m_addr = '0;
      qa.delete();
      qp.delete();
      ai.due = cyc + 1; ai.addr = '0;
      qa.push_back(ai);
      for (int k = 1; k <= 3; k++) begin
        pi.due = cyc + k; pi.v = 1'b0; pi.pal = 4'd0;
        qp.push_back(pi);
      end
    end else begin
      inb = (s.x >= m_sx) && (s.x < m_sx + 64) && (s.y >= m_sy) && (s.y < m_sy + 96);
      if (inb) begin
        col    = m_face ? 63 - (s.x - m_sx) : s.x - m_sx;
        row    = s.y - m_sy;
        m_addr = 15'(m_frame * 6144 + row * 64 + col);
      end
      ai.due = cyc + 1; ai.addr = m_addr;
      qa.push_back(ai);
      d      = rom_val(m_addr);
      pi.due = cyc + 3;
      pi.v   = inb && (d != 4'd0);
      pi.pal = pi.v ? d : 4'd0;
      qp.push_back(pi);
      if (s.fs) begin
        m_sx = s.sx; m_sy = s.sy; m_face = s.face;
        if (s.en) begin
          if (m_div == 7) begin
            m_div   = 0;
            m_frame = (m_frame + 1) % 4;
          end else begin
            m_div++;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic stim_t px(int x, int y, int sx, int sy);
    stim_t s;
    s.r = 1'b0; s.x = x; s.y = y; s.fs = 1'b0; s.sx = sx; s.sy = sy;
    s.face = 1'b0; s.en = 1'b0;
    return s;
  endfunction

  function automatic stim_t fsp(int x, int y, int sx, int sy, logic face, logic en);
    stim_t s;
    s = px(x, y, sx, sy);
    s.fs = 1'b1; s.face = face; s.en = en;
    return s;
  endfunction

  function automatic stim_t rstp(int x, int y);
    stim_t s;
    s = px(x, y, 0, 0);
    s.r = 1'b1;
    return s;
  endfunction

  task automatic test_reset();
    stim_t st[$];
    a_item_t ea;
    p_item_t ep;
    st.push_back(rstp(0, 0));
    st.push_back(rstp(0, 0));
    st.push_back(rstp(0, 0));
    foreach (st[i]) begin
      step(st[i]);
      while (qa.size() > 0 && qa[0].due == cyc) begin
        ea = qa.pop_front(); checks++;
        if (bus.rom_addr !== ea.addr) begin
          failures++;
          $display("FAIL reset rom_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_addr, ea.addr);
        end
      end
      while (qp.size() > 0 && qp[0].due == cyc) begin
        ep = qp.pop_front(); checks++;
        if (bus.pixel_valid !== ep.v || bus.pal_index !== ep.pal) begin
          failures++;
          $display("FAIL reset pixel cyc=%0d got v=%0b pal=%0d exp v=%0b pal=%0d",
                   cyc, bus.pixel_valid, bus.pal_index, ep.v, ep.pal);
        end
      end
    end
  endtask

  task automatic test_basic();
    stim_t st[$];
    a_item_t ea;
    p_item_t ep;
    st.push_back(fsp(300, 300, 100, 50, 1'b0, 1'b0));
    st.push_back(px(100, 50, 0, 0));    // rom_addr 0, data 5
    st.push_back(px(101, 50, 0, 0));
    st.push_back(px(111, 50, 0, 0));    // transparent entry
    st.push_back(px(163, 50, 0, 0));    // last column
    st.push_back(px(164, 50, 0, 0));    // first column past edge
    st.push_back(px(99, 50, 0, 0));
    st.push_back(px(100, 145, 0, 0));   // last row
    st.push_back(px(100, 146, 0, 0));   // first row past edge
    st.push_back(px(100, 49, 0, 0));
    st.push_back(px(163, 145, 0, 0));
    for (int x = 96; x < 170; x++) st.push_back(px(x, 60, 0, 0));
    for (int k = 0; k < 3; k++) st.push_back(px(500, 500, 0, 0));
    foreach (st[i]) begin
      step(st[i]);
      while (qa.size() > 0 && qa[0].due == cyc) begin
        ea = qa.pop_front(); checks++;
        if (bus.rom_addr !== ea.addr) begin
          failures++;
          $display("FAIL basic rom_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_addr, ea.addr);
        end
      end
      while (qp.size() > 0 && qp[0].due == cyc) begin
        ep = qp.pop_front(); checks++;
        if (bus.pixel_valid !== ep.v || bus.pal_index !== ep.pal) begin
          failures++;
          $display("FAIL basic pixel cyc=%0d got v=%0b pal=%0d exp v=%0b pal=%0d",
                   cyc, bus.pixel_valid, bus.pal_index, ep.v, ep.pal);
        end
      end
    end
  endtask

  task automatic test_mirror_midframe();
    stim_t st[$];
    stim_t s;
    a_item_t ea;
    p_item_t ep;
    st.push_back(fsp(500, 500, 100, 50, 1'b1, 1'b0));
    st.push_back(px(100, 51, 100, 50)); // mirrored: 1*64+63 = 127
    st.push_back(px(163, 51, 100, 50));
    st.push_back(px(164, 51, 100, 50));
    st.push_back(px(100, 50, 100, 50));
    // Position/facing change on the bus without a frame_start
    for (int x = 98; x < 106; x++) begin
      s = px(x, 52, 200, 50); s.face = 1'b0; st.push_back(s);
    end
    st.push_back(px(200, 52, 200, 50));
    st.push_back(fsp(500, 500, 200, 50, 1'b0, 1'b0));
    st.push_back(px(200, 52, 200, 50));
    st.push_back(px(100, 52, 200, 50));
    st.push_back(px(263, 52, 200, 50));
    st.push_back(px(264, 52, 200, 50));
    for (int k = 0; k < 3; k++) st.push_back(px(0, 0, 200, 50));
    foreach (st[i]) begin
      step(st[i]);
      while (qa.size() > 0 && qa[0].due == cyc) begin
        ea = qa.pop_front(); checks++;
        if (bus.rom_addr !== ea.addr) begin
          failures++;
          $display("FAIL mirror rom_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_addr, ea.addr);
        end
      end
      while (qp.size() > 0 && qp[0].due == cyc) begin
        ep = qp.pop_front(); checks++;
        if (bus.pixel_valid !== ep.v || bus.pal_index !== ep.pal) begin
          failures++;
          $display("FAIL mirror pixel cyc=%0d got v=%0b pal=%0d exp v=%0b pal=%0d",
                   cyc, bus.pixel_valid, bus.pal_index, ep.v, ep.pal);
        end
      end
    end
  endtask

  task automatic test_anim();
    stim_t st[$];
    a_item_t ea;
    p_item_t ep;
    for (int p = 0; p < 34; p++) begin
      // Pulse coincides with an in-bounds pixel, which must use old state
      st.push_back(fsp(100, 50, 100, 50, 1'b0, 1'b1));
      st.push_back(px(100, 50, 100, 50));
      st.push_back(px(110, 55, 100, 50));
      if (p % 5 == 2) st.push_back(fsp(101, 50, 100, 50, 1'b0, 1'b0)); // held
    end
    for (int k = 0; k < 3; k++) st.push_back(px(0, 0, 100, 50));
    foreach (st[i]) begin
      step(st[i]);
      while (qa.size() > 0 && qa[0].due == cyc) begin
        ea = qa.pop_front(); checks++;
        if (bus.rom_addr !== ea.addr) begin
          failures++;
          $display("FAIL anim rom_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_addr, ea.addr);
        end
      end
      while (qp.size() > 0 && qp[0].due == cyc) begin
        ep = qp.pop_front(); checks++;
        if (bus.pixel_valid !== ep.v || bus.pal_index !== ep.pal) begin
          failures++;
          $display("FAIL anim pixel cyc=%0d got v=%0b pal=%0d exp v=%0b pal=%0d",
                   cyc, bus.pixel_valid, bus.pal_index, ep.v, ep.pal);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    stim_t s;
    a_item_t ea;
    p_item_t ep;
    for (int k = 0; k < 300; k++) begin
      s = px(90 + int'($urandom_range(0, 90)), 40 + int'($urandom_range(0, 120)),
             90 + int'($urandom_range(0, 20)), 40 + int'($urandom_range(0, 20)));
      s.fs   = ($urandom_range(0, 19) == 0);
      s.face = 1'($urandom_range(0, 1));
      s.en   = 1'($urandom_range(0, 1));
      st.push_back(s);
    end
    // Sprite hanging off the bottom-right corner must not wrap
    st.push_back(fsp(0, 0, 1000, 1000, 1'b0, 1'b0));
    st.push_back(px(1023, 1023, 0, 0));
    st.push_back(px(1000, 1000, 0, 0));
    st.push_back(px(5, 5, 0, 0));
    st.push_back(px(1023, 5, 0, 0));
    st.push_back(px(5, 1023, 0, 0));
    for (int k = 0; k < 3; k++) st.push_back(px(0, 0, 0, 0));
    foreach (st[i]) begin
      step(st[i]);
      while (qa.size() > 0 && qa[0].due == cyc) begin
        ea = qa.pop_front(); checks++;
        if (bus.rom_addr !== ea.addr) begin
          failures++;
          $display("FAIL b2b rom_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_addr, ea.addr);
        end
      end
      while (qp.size() > 0 && qp[0].due == cyc) begin
        ep = qp.pop_front(); checks++;
        if (bus.pixel_valid !== ep.v || bus.pal_index !== ep.pal) begin
          failures++;
          $display("FAIL b2b pixel cyc=%0d got v=%0b pal=%0d exp v=%0b pal=%0d",
                   cyc, bus.pixel_valid, bus.pal_index, ep.v, ep.pal);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    stim_t st[$];
    a_item_t ea;
    p_item_t ep;
    for (int p = 0; p < 8; p++) st.push_back(fsp(100, 50, 100, 50, 1'b1, 1'b1));
    for (int x = 100; x < 106; x++) st.push_back(px(x, 50, 100, 50));
    st.push_back(rstp(102, 50));
    st.push_back(rstp(103, 50));
    for (int x = 0; x < 8; x++) st.push_back(px(x, 0, 100, 50));
    for (int k = 0; k < 3; k++) st.push_back(px(500, 500, 100, 50));
    foreach (st[i]) begin
      step(st[i]);
      while (qa.size() > 0 && qa[0].due == cyc) begin
        ea = qa.pop_front(); checks++;
        if (bus.rom_addr !== ea.addr) begin
          failures++;
          $display("FAIL rst_mid rom_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rom_addr, ea.addr);
        end
      end
      while (qp.size() > 0 && qp[0].due == cyc) begin
        ep = qp.pop_front(); checks++;
        if (bus.pixel_valid !== ep.v || bus.pal_index !== ep.pal) begin
          failures++;
          $display("FAIL rst_mid pixel cyc=%0d got v=%0b pal=%0d exp v=%0b pal=%0d",
                   cyc, bus.pixel_valid, bus.pal_index, ep.v, ep.pal);
        end
      end
    end
  endtask

  initial begin
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.frame_start = 1'b0;
    bus.SpriteX     = '0;
    bus.SpriteY     = '0;
    bus.facing_left = 1'b0;
    bus.anim_enable = 1'b0;
    bus.rom_data    = '0;
    m_sx = 0; m_sy = 0; m_face = 1'b0; m_frame = 0; m_div = 0; m_addr = '0;

    test_reset();
    test_basic();
    test_mirror_midframe();
    test_anim();
    test_back_to_back();
    test_reset_midrun();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
